instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 128, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 7, word-address width; it SHALL equal log2(MEM_DEPTH).
REQ-003 SHALL have parameter HALT_WORD, default 32'hFC00_0000, the sentinel instruction that stops fetch.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  leave IDLE and begin fetching at the current PC.
REQ-007 imem_cs  output  1  instruction memory read strobe.
REQ-008 imem_addr  output  ADDR_W  instruction memory word address.
REQ-009 imem_rdata  input  32  read data, valid exactly one cycle after imem_cs=1.
REQ-010 redirect  input  1  branch/jump redirect request.
REQ-011 redirect_pc  input  ADDR_W  redirect target word address.
REQ-012 instrword  output  32  instruction presented to the CPU.
REQ-013 newinstr  output  1  instrword valid; held until accepted.
REQ-014 instr_ready  input  1  CPU accepts instrword when newinstr=1 and instr_ready=1.
REQ-015 pc_out  output  ADDR_W  word address of instrword.
REQ-016 halted  output  1  HALT_WORD accepted; fetch stopped.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, HOLD and HALT.
REQ-018 IDLE: when start=1, SHALL drive imem_cs=1 and imem_addr=pc, then go to FETCH.
REQ-019 FETCH: SHALL latch instrword=imem_rdata and pc_out=pc, assert newinstr=1, set pc<=pc+1, then go to HOLD.
REQ-020 HOLD: newinstr, instrword and pc_out SHALL stay stable until accepted.
REQ-021 HOLD, on acceptance of a non-HALT_WORD instruction: SHALL issue a fetch at pc and go to FETCH; newinstr SHALL drop for that cycle.
REQ-022 HOLD, on acceptance of HALT_WORD: SHALL go to HALT with halted=1 and imem_cs=0; only reset SHALL leave HALT.
REQ-023 Throughput without PREFETCH_EN SHALL be one instruction per two cycles when instr_ready is held at 1.
REQ-024 PC arithmetic SHALL be modulo MEM_DEPTH: PC MEM_DEPTH-1 increments to 0.
REQ-025 Redirect in FETCH or HOLD: SHALL discard any in-flight or held instruction, set pc<=redirect_pc, issue a fetch at redirect_pc in the next cycle, and deassert newinstr until that data returns.
REQ-026 Redirect and acceptance in the same cycle: the presented instruction SHALL count as accepted; the redirect SHALL then apply, and the redirect SHALL override the sequential pc+1.
REQ-027 Redirect SHALL be ignored in IDLE and HALT.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 imem_cs SHALL be 1 only in the cycle a fetch is issued.

Reset
REQ-030 With reset=0 at a rising edge: state SHALL become IDLE and pc=0.
REQ-031 With reset=0 at a rising edge: instrword, pc_out and imem_addr SHALL become 0.
REQ-032 With reset=0 at a rising edge: newinstr, imem_cs and halted SHALL become 0.
REQ-033 With reset=0 at a rising edge: any prefetch buffer SHALL become empty.
REQ-034 Reset SHALL take effect at the next edge even mid-fetch, and the in-flight imem_rdata SHALL be discarded.

Configuration
REQ-035 Macro PREFETCH_EN defined: a 2-entry buffer SHALL be present, and a fetch SHALL be issued every cycle the buffer has a free slot.
REQ-036 With PREFETCH_EN, throughput SHALL be one instruction per cycle with instr_ready=1.
REQ-037 With PREFETCH_EN, redirect and reset SHALL flush both buffer entries and the in-flight fetch.
REQ-038 With PREFETCH_EN, no fetch SHALL be issued beyond a buffered HALT_WORD.
REQ-039 Macro PREFETCH_EN undefined: behaviour SHALL be exactly REQ-017..REQ-029.

Structure
REQ-040 Package gforce_pkg SHALL hold the FSM state typedef, the HALT_WORD default and the ADDR_W default.
REQ-041 The prefetch buffer SHALL be sub-module fetch_buffer, a 2-entry FIFO of {pc, instr} with push/pop/flush/full/empty, instantiated only under PREFETCH_EN.

Verification
REQ-042 Memory words 0..3 = 0x00221820, 0x8C010004, 0xAC010008, HALT_WORD; instr_ready=1; start pulse -> four newinstr handshakes with pc_out 0,1,2,3 (2 cycles apart; 1 apart with PREFETCH_EN), then halted=1 and no further imem_cs.
REQ-043 instr_ready=0 for 5 cycles at pc_out=1 -> instrword stays 0x8C010004 and newinstr stays 1 for all 5 cycles; pc_out=2 appears after acceptance.
REQ-044 Redirect with redirect_pc=0x40 while HOLD at pc_out=2 -> pc_out=2 never accepted; next newinstr shows pc_out=0x40 with the word at address 0x40.
REQ-045 Redirect with redirect_pc=5 in the same cycle as acceptance of pc_out=1 -> pc_out=1 counted accepted; next newinstr shows pc_out=5.
REQ-046 Start at pc=127 with word 127 non-halt -> after pc_out=127, next pc_out=0.
REQ-047 reset=0 during FETCH -> next cycle all outputs 0 and state IDLE; a fresh start fetches address 0.

Source files
------------

// File: rtl/gforce_pkg.sv
// Shared types and parameter defaults for the instruction fetch unit.
package gforce_pkg;

    localparam int unsigned ADDR_W_DEF    = 7;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFC00_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO used as the prefetch buffer.
// Only compiled when PREFETCH_EN is defined, since only that build instantiates it.
`ifdef PREFETCH_EN
module fetch_buffer
    import gforce_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [31:0]       push_instr,
    output logic [ADDR_W-1:0] head_pc,
    output logic [31:0]       head_instr,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] pc_q    [2];
    logic [31:0]       instr_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign full       = (count == 2'd2);
    assign empty      = (count == 2'd0);
    assign head_pc    = pc_q[rd_ptr];
    assign head_instr = instr_q[rd_ptr];
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= '0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                pc_q[wr_ptr]    <= push_pc;
                instr_q[wr_ptr] <= push_instr;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule
`endif

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads words from instruction memory and hands them to the CPU.
// Define PREFETCH_EN for a 2-entry prefetch buffer giving one instruction per cycle.
module instr_fetch
    import gforce_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 128,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              imem_cs,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instrword,
    output logic              newinstr,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    fetch_state_e      state;
    fetch_state_e      state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc = (pc == ADDR_W'(MEM_DEPTH - 1)) ? '0 : pc + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

`ifdef PREFETCH_EN
    logic              accept;
    logic              accept_halt;
    logic              redir;
    logic              inflight;
    logic              halt_seen;
    logic              arrive_halt;
    logic              room;
    logic              issue_run;
    logic              buf_push;
    logic              buf_flush;
    logic              buf_full;
    logic              buf_empty;
    logic [2:0]        occ;
    logic [ADDR_W-1:0] inflight_pc;
    logic [ADDR_W-1:0] head_pc;
    logic [31:0]       head_instr;

    // A slot is free if the entries held plus the one in flight, minus this cycle's pop, leave room.
    assign occ         = {1'b0, buf_full, !buf_full && !buf_empty} + {2'b0, inflight};
    assign accept      = !buf_empty && instr_ready;
    assign accept_halt = accept && (head_instr == HALT_WORD);
    assign redir       = redirect && (state == ST_FETCH) && !accept_halt;
    assign arrive_halt = inflight && (imem_rdata == HALT_WORD);
    assign room        = occ <= (3'd1 + {2'b0, accept});
    assign buf_push    = inflight && (state == ST_FETCH) && !redir;
    assign buf_flush   = redir || accept_halt;
    assign issue_run   = (state == ST_FETCH) && !redir && !accept_halt
                         && !halt_seen && !arrive_halt && room;

    fetch_buffer #(
        .ADDR_W(ADDR_W)
    ) u_fetch_buffer (
        .clock      (clock),
        .reset      (reset),
        .push       (buf_push),
        .pop        (accept),
        .flush      (buf_flush),
        .push_pc    (inflight_pc),
        .push_instr (imem_rdata),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_FETCH;
            ST_FETCH: if (accept_halt) state_nx = ST_HALT;
            ST_HOLD:  state_nx = ST_FETCH;
            ST_HALT:  state_nx = ST_HALT;
        endcase
    end

    always_comb begin
        imem_cs   = ((state == ST_IDLE) && start) || issue_run;
        imem_addr = pc;
        halted    = (state == ST_HALT);
        newinstr  = !buf_empty;
        instrword = head_instr;
        pc_out    = head_pc;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            halt_seen   <= 1'b0;
        end else begin
            inflight <= imem_cs;
            if (imem_cs) begin
                inflight_pc <= pc;
                pc          <= pc_inc;
            end
            if (redir) begin
                pc        <= redirect_pc;
                halt_seen <= 1'b0;
            end else if (buf_push && arrive_halt) begin
                halt_seen <= 1'b1;
            end
        end
    end
`else
    logic accept;
    logic accept_halt;
    logic redir;
    logic issue_hold;

    // HOLD with nothing presented (after a redirect) simply issues the pending fetch at pc.
    assign accept      = newinstr && instr_ready;
    assign accept_halt = accept && (instrword == HALT_WORD);
    assign redir       = redirect && !accept_halt
                         && ((state == ST_FETCH) || (state == ST_HOLD));
    assign issue_hold  = (state == ST_HOLD) && !redir && !accept_halt
                         && (!newinstr || accept);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_FETCH;
            ST_FETCH: state_nx = ST_HOLD;
            ST_HOLD: begin
                if (accept_halt) begin
                    state_nx = ST_HALT;
                end else if (issue_hold) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_HALT:  state_nx = ST_HALT;
        endcase
    end

    always_comb begin
        imem_cs   = ((state == ST_IDLE) && start) || issue_hold;
        imem_addr = pc;
        halted    = (state == ST_HALT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc        <= '0;
            instrword <= '0;
            pc_out    <= '0;
            newinstr  <= 1'b0;
        end else if (state == ST_FETCH) begin
            if (redir) begin
                pc <= redirect_pc;
            end else begin
                instrword <= imem_rdata;
                pc_out    <= pc;
                newinstr  <= 1'b1;
                pc        <= pc_inc;
            end
        end else if (state == ST_HOLD) begin
            if (accept) begin
                newinstr <= 1'b0;
            end
            if (redir) begin
                pc       <= redirect_pc;
                newinstr <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected {pc, instr} handshakes,
// a negedge monitor compares them against a simple sequential-program model.
module tb_instr_fetch;

    localparam logic [31:0] HALT = 32'hFC00_0000;
`ifdef PREFETCH_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 2;
`endif

    typedef struct {
        logic [6:0]  pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        imem_cs;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [6:0]  redirect_pc = '0;
    logic [31:0] instrword;
    logic        newinstr;
    logic        instr_ready = 1'b0;
    logic [6:0]  pc_out;
    logic        halted;

    logic [31:0] mem [128];
    exp_t        sb_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          last_hs = 0;
    bit          last_hs_valid = 0;
    bit          gap_en = 0;
    bit          model_running = 0;
    bit          halt_pending = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_instr;
    logic [6:0]  prev_pc;

    instr_fetch #(
        .MEM_DEPTH(128),
        .ADDR_W   (7),
        .HALT_WORD(HALT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .imem_cs    (imem_cs),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instrword  (instrword),
        .newinstr   (newinstr),
        .instr_ready(instr_ready),
        .pc_out     (pc_out),
        .halted     (halted)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory returns data one cycle after the strobe; garbage otherwise.
    always @(posedge clock) begin
        imem_rdata <= imem_cs ? mem[imem_addr] : $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) begin
            sb_q.delete();
            model_running = 0;
            halt_pending  = 0;
            last_hs_valid = 0;
            prev_hold     = 0;
        end else begin
            if (halt_pending) begin
                check("halted_after_halt_word", 32'(halted), 32'd1);
                halt_pending = 0;
            end
            if (halted) check("no_fetch_when_halted", 32'(imem_cs), 32'd0);
            if (prev_hold) begin
                check("hold_newinstr", 32'(newinstr), 32'd1);
                check("hold_instrword", instrword, prev_instr);
                check("hold_pc_out", 32'(pc_out), 32'(prev_pc));
            end
            if (newinstr && instr_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_handshake actual=pc_out %0d required=no handshake", pc_out);
                end else begin
                    e = sb_q.pop_front();
                    check("handshake_pc", 32'(pc_out), 32'(e.pc));
                    check("handshake_instr", instrword, e.instr);
                    hs_count++;
                    if (gap_en && last_hs_valid) check("handshake_gap", cyc - last_hs, EXP_GAP);
                    last_hs = cyc;
                    last_hs_valid = 1;
                    if (e.instr == HALT) begin
                        model_running = 0;
                        halt_pending  = 1;
                    end else begin
                        e.pc = 7'((int'(e.pc) + 1) % 128);
                        e.instr = mem[e.pc];
                        sb_q.push_back(e);
                    end
                end
            end
            if (redirect && model_running) begin
                sb_q.delete();
                e.pc = redirect_pc;
                e.instr = mem[redirect_pc];
                sb_q.push_back(e);
            end
            prev_hold  = newinstr && !instr_ready && !(redirect && model_running);
            prev_instr = instrword;
            prev_pc    = pc_out;
        end
    end

    task automatic load_prog();
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = mem[i] ^ 32'd1;
        end
        mem[0] = 32'h0022_1820;
        mem[1] = 32'h8C01_0004;
        mem[2] = 32'hAC01_0008;
        mem[3] = HALT;
    endtask

    task automatic reset_dut();
        @(posedge clock); #1;
        reset = 0; start = 0; redirect = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    task automatic do_start();
        exp_t e;
        @(posedge clock); #1;
        redirect = 0;
        start = 1;
        e.pc = 7'd0;
        e.instr = mem[0];
        sb_q.push_back(e);
        model_running = 1;
        @(posedge clock); #1;
        start = 0;
    endtask

    task automatic wait_present(input logic [6:0] p, input string name);
        bit found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clock);
            if (newinstr && pc_out == p) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s actual=timeout required=newinstr with pc_out %0d", name, p);
        end
    endtask

    task automatic wait_halted(input string name);
        bit found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clock);
            if (halted) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s actual=timeout required=halted", name);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_cs"}, 32'(imem_cs), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_instrword"}, instrword, 32'd0);
        check({tag, "_newinstr"}, 32'(newinstr), 32'd0);
        check({tag, "_pc_out"}, 32'(pc_out), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=still running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin : stimulus
        int base;
        load_prog();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        #1 reset = 1;

        // Straight-line program ending in HALT_WORD, CPU always ready.
        instr_ready = 1;
        gap_en = 1;
        base = hs_count;
        do_start();
        wait_halted("prog_halt");
        gap_en = 0;
        repeat (10) @(negedge clock);
        check("prog_handshakes", hs_count - base, 4);

        // CPU stalls on pc_out=1 for five cycles.
        reset_dut();
        instr_ready = 1;
        do_start();
        wait_present(7'd0, "stall_pc0");
        @(posedge clock); #1 instr_ready = 0;
        wait_present(7'd1, "stall_pc1");
        for (int i = 0; i < 5; i++) begin
            check("stall_newinstr", 32'(newinstr), 32'd1);
            check("stall_instrword", instrword, 32'h8C01_0004);
            if (i < 4) @(negedge clock);
        end
        @(posedge clock); #1 instr_ready = 1;
        wait_halted("stall_halt");

        // Redirect to 0x40 while pc_out=2 is held.
        reset_dut();
        instr_ready = 1;
        do_start();
        wait_present(7'd1, "redir_hold_pc1");
        @(posedge clock); #1 instr_ready = 0;
        wait_present(7'd2, "redir_hold_pc2");
        @(posedge clock); #1 redirect = 1; redirect_pc = 7'h40;
        @(posedge clock); #1 redirect = 0; instr_ready = 1;
        wait_present(7'h40, "redir_hold_target");
        repeat (10) @(negedge clock);

        // Redirect to 5 in the same cycle pc_out=1 is accepted.
        reset_dut();
        instr_ready = 1;
        do_start();
        wait_present(7'd0, "redir_acc_pc0");
        @(posedge clock); #1 instr_ready = 0;
        wait_present(7'd1, "redir_acc_pc1");
        base = hs_count;
        @(posedge clock); #1 instr_ready = 1; redirect = 1; redirect_pc = 7'd5;
        @(posedge clock); #1 redirect = 0;
        wait_present(7'd5, "redir_acc_target");
        check("redir_acc_pc1_accepted", hs_count - base, 1);

        // PC wraps from 127 to 0.
        reset_dut();
        instr_ready = 0;
        do_start();
        wait_present(7'd0, "wrap_pc0");
        @(posedge clock); #1 redirect = 1; redirect_pc = 7'd127;
        @(posedge clock); #1 redirect = 0; instr_ready = 1;
        wait_present(7'd127, "wrap_pc127");
        wait_present(7'd0, "wrap_to_0");
        wait_halted("wrap_halt");

        // Reset mid-fetch discards the in-flight word.
        reset_dut();
        instr_ready = 1;
        do_start();
        reset = 0;
        @(posedge clock);
        @(negedge clock);
        check_all_zero("midfetch_reset");
        #1 reset = 1;
        do_start();
        wait_halted("midfetch_restart_halt");

        // Random ready/redirect traffic, including redirects in IDLE and HALT.
        for (int r = 0; r < 4; r++) begin
            reset_dut();
            load_prog();
            mem[3] = 32'h0000_0020;
            mem[100] = HALT;
            repeat (3) begin
                @(posedge clock); #1 redirect = 1; redirect_pc = 7'($urandom);
            end
            do_start();
            for (int c = 0; c < 300; c++) begin
                @(posedge clock); #1;
                instr_ready = ($urandom_range(3) != 0);
                redirect    = ($urandom_range(15) == 0);
                redirect_pc = 7'($urandom);
            end
            redirect = 0;
            repeat (3) @(negedge clock);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
